// File: rtl/ddr_ctrl_fifo_pkg.sv
// ddr_ctrl_fifo_pkg: shared helpers and status-flag layout for the DDR controller FIFOs
// Contents: fifo_aw() pointer width helper, ptr_inc() wrap-aware pointer increment,
//           FLG_* bit indices of the registered status vector and its reset value.
package ddr_ctrl_fifo_pkg;

    localparam int FLG_FULL   = 0;
    localparam int FLG_EMPTY  = 1;
    localparam int FLG_AFULL  = 2;
    localparam int FLG_AEMPTY = 3;
    localparam int FLG_W      = 4;

    // Reset/flush state: empty and almost-empty asserted, everything else clear
    localparam logic [FLG_W-1:0] FLG_RST = 4'b1010;

    function automatic int fifo_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Wraps at depth-1 explicitly so non power-of-2 depths work
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/ddr_ctrl_fifo_ram.sv
// ddr_ctrl_fifo_ram: simple dual-port storage, registered write, combinational read
// Ports: Sys_Clk clock; I_We/I_Wr_Addr/I_Wr_Data write port; I_Rd_Addr/O_Rd_Data async read port.
// Storage has no reset.
module ddr_ctrl_fifo_ram
    import ddr_ctrl_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_DEPTH = 16,
    localparam int AW = fifo_aw(DATA_DEPTH)
)(
    input  logic                  Sys_Clk,
    input  logic                  I_We,
    input  logic [AW-1:0]         I_Wr_Addr,
    input  logic [DATA_WIDTH-1:0] I_Wr_Data,
    input  logic [AW-1:0]         I_Rd_Addr,
    output logic [DATA_WIDTH-1:0] O_Rd_Data
);

    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

    always_ff @(posedge Sys_Clk)
        if (I_We) mem[I_Wr_Addr] <= I_Wr_Data;

    assign O_Rd_Data = mem[I_Rd_Addr];

endmodule

// File: rtl/ddr_ctrl_sc_fifo_fwft.sv
// ddr_ctrl_sc_fifo_fwft: single-clock first-word-fall-through FIFO with watermarks and sticky error flags
// Ports: Sys_Clk/Sys_Rst (async, active-high)/Sync_Clr (synchronous flush);
//        I_Wr_En/I_Wr_Data push; I_Rd_En pop (acknowledges O_Rd_Data);
//        O_Rd_Data head word; O_Data_Num occupancy; O_Wr_Full/O_Rd_Empty;
//        O_Almost_Full/O_Almost_Empty watermarks; O_Fifo_Err rejected-access pulse;
//        O_Ovf_Sticky/O_Udf_Sticky latched overflow/underflow.
// Optional: define DDR_FIFO_PEAK_STAT_EN to add I_Peak_Clr and the O_Peak_Num high-water mark.
module ddr_ctrl_sc_fifo_fwft
    import ddr_ctrl_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int DATA_DEPTH    = 16,
    parameter int AFULL_THRESH  = DATA_DEPTH - 2,
    parameter int AEMPTY_THRESH = 2,
    localparam int AW = fifo_aw(DATA_DEPTH)
)(
    input  logic                  Sys_Clk,
    input  logic                  Sys_Rst,
    input  logic                  Sync_Clr,
    input  logic                  I_Wr_En,
    input  logic [DATA_WIDTH-1:0] I_Wr_Data,
    input  logic                  I_Rd_En,
`ifdef DDR_FIFO_PEAK_STAT_EN
    input  logic                  I_Peak_Clr,
    output logic [AW:0]           O_Peak_Num,
`endif
    output logic [DATA_WIDTH-1:0] O_Rd_Data,
    output logic [AW:0]           O_Data_Num,
    output logic                  O_Wr_Full,
    output logic                  O_Rd_Empty,
    output logic                  O_Almost_Full,
    output logic                  O_Almost_Empty,
    output logic                  O_Fifo_Err,
    output logic                  O_Ovf_Sticky,
    output logic                  O_Udf_Sticky
);

    localparam logic [AW:0] CNT_MAX = (AW+1)'(DATA_DEPTH);
    localparam logic [AW:0] AF_LVL  = (AW+1)'(AFULL_THRESH);
    localparam logic [AW:0] AE_LVL  = (AW+1)'(AEMPTY_THRESH);
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

    logic [AW-1:0]         wr_ptr, rd_ptr, wr_ptr_inc, rd_ptr_nxt;
    logic [AW:0]           cnt, cnt_nxt;
    logic [FLG_W-1:0]      flags, flags_nxt;
    logic [DATA_WIDTH-1:0] ram_rd;
    logic                  wr_acc, rd_acc, bypass;

    assign wr_acc = I_Wr_En & ~flags[FLG_FULL];
    assign rd_acc = I_Rd_En & ~flags[FLG_EMPTY];

    always_comb begin
        wr_ptr_inc = AW'(ptr_inc(32'(wr_ptr), DATA_DEPTH));
        rd_ptr_nxt = rd_acc ? AW'(ptr_inc(32'(rd_ptr), DATA_DEPTH)) : rd_ptr;
        cnt_nxt    = (wr_acc && !rd_acc) ? cnt + CNT_ONE :
                     (rd_acc && !wr_acc) ? cnt - CNT_ONE : cnt;
        // New head is the word being written now (FIFO empty after this edge's read), not yet in RAM
        bypass     = wr_acc && (wr_ptr == rd_ptr_nxt);
        flags_nxt  = '0;
        flags_nxt[FLG_FULL]   = cnt_nxt == CNT_MAX;
        flags_nxt[FLG_EMPTY]  = cnt_nxt == '0;
        flags_nxt[FLG_AFULL]  = cnt_nxt >= AF_LVL;
        flags_nxt[FLG_AEMPTY] = cnt_nxt <= AE_LVL;
    end

    ddr_ctrl_fifo_ram #(.DATA_WIDTH(DATA_WIDTH), .DATA_DEPTH(DATA_DEPTH)) u_ram (
        .Sys_Clk   (Sys_Clk),
        .I_We      (wr_acc & ~Sync_Clr),
        .I_Wr_Addr (wr_ptr),
        .I_Wr_Data (I_Wr_Data),
        .I_Rd_Addr (rd_ptr_nxt),
        .O_Rd_Data (ram_rd)
    );

    always_ff @(posedge Sys_Clk or posedge Sys_Rst)
        if (Sys_Rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            cnt          <= '0;
            flags        <= FLG_RST;
            O_Rd_Data    <= '0;
            O_Fifo_Err   <= 1'b0;
            O_Ovf_Sticky <= 1'b0;
            O_Udf_Sticky <= 1'b0;
        end else if (Sync_Clr) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            cnt          <= '0;
            flags        <= FLG_RST;
            O_Rd_Data    <= '0;
            O_Fifo_Err   <= 1'b0;
            O_Ovf_Sticky <= 1'b0;
            O_Udf_Sticky <= 1'b0;
        end else begin
            wr_ptr       <= wr_acc ? wr_ptr_inc : wr_ptr;
            rd_ptr       <= rd_ptr_nxt;
            cnt          <= cnt_nxt;
            flags        <= flags_nxt;
            // Hold the last word when the FIFO drains so the output never shows stale RAM
            O_Rd_Data    <= bypass ? I_Wr_Data : (cnt_nxt != '0) ? ram_rd : O_Rd_Data;
            O_Fifo_Err   <= (I_Wr_En & flags[FLG_FULL]) | (I_Rd_En & flags[FLG_EMPTY]);
            O_Ovf_Sticky <= O_Ovf_Sticky | (I_Wr_En & flags[FLG_FULL]);
            O_Udf_Sticky <= O_Udf_Sticky | (I_Rd_En & flags[FLG_EMPTY]);
        end

`ifdef DDR_FIFO_PEAK_STAT_EN
    always_ff @(posedge Sys_Clk or posedge Sys_Rst)
        if (Sys_Rst) O_Peak_Num <= '0;
        else if (Sync_Clr) O_Peak_Num <= '0;
        else if (I_Peak_Clr) O_Peak_Num <= cnt_nxt;
        else O_Peak_Num <= (cnt_nxt > O_Peak_Num) ? cnt_nxt : O_Peak_Num;
`endif

    assign O_Data_Num     = cnt;
    assign O_Wr_Full      = flags[FLG_FULL];
    assign O_Rd_Empty     = flags[FLG_EMPTY];
    assign O_Almost_Full  = flags[FLG_AFULL];
    assign O_Almost_Empty = flags[FLG_AEMPTY];

endmodule

// File: tb/tb_ddr_ctrl_sc_fifo_fwft.sv
// tb_ddr_ctrl_sc_fifo_fwft: directed and scoreboard checks of the FWFT FIFO at depth 5
module tb_ddr_ctrl_sc_fifo_fwft;

    localparam int DW = 8;
    localparam int DD = 5;

    logic          Sys_Clk = 1'b0;
    logic          Sys_Rst = 1'b1;
    logic          Sync_Clr = 1'b0;
    logic          I_Wr_En = 1'b0;
    logic [DW-1:0] I_Wr_Data = '0;
    logic          I_Rd_En = 1'b0;
    logic [DW-1:0] O_Rd_Data;
    logic [3:0]    O_Data_Num;
    logic          O_Wr_Full, O_Rd_Empty, O_Almost_Full, O_Almost_Empty;
    logic          O_Fifo_Err, O_Ovf_Sticky, O_Udf_Sticky;
    logic [6:0]    st;

    int n_chk = 0;
    int n_fail = 0;

    // Status order: full, empty, afull, aempty, err, ovf, udf
    assign st = {O_Wr_Full, O_Rd_Empty, O_Almost_Full, O_Almost_Empty, O_Fifo_Err, O_Ovf_Sticky, O_Udf_Sticky};

    always #5 Sys_Clk = ~Sys_Clk;

    ddr_ctrl_sc_fifo_fwft #(.DATA_WIDTH(DW), .DATA_DEPTH(DD), .AFULL_THRESH(3), .AEMPTY_THRESH(2)) dut (
        .Sys_Clk        (Sys_Clk),
        .Sys_Rst        (Sys_Rst),
        .Sync_Clr       (Sync_Clr),
        .I_Wr_En        (I_Wr_En),
        .I_Wr_Data      (I_Wr_Data),
        .I_Rd_En        (I_Rd_En),
        .O_Rd_Data      (O_Rd_Data),
        .O_Data_Num     (O_Data_Num),
        .O_Wr_Full      (O_Wr_Full),
        .O_Rd_Empty     (O_Rd_Empty),
        .O_Almost_Full  (O_Almost_Full),
        .O_Almost_Empty (O_Almost_Empty),
        .O_Fifo_Err     (O_Fifo_Err),
        .O_Ovf_Sticky   (O_Ovf_Sticky),
        .O_Udf_Sticky   (O_Udf_Sticky)
    );

    task automatic tick;
        @(posedge Sys_Clk);
        #1;
    endtask

    task automatic flush;
        I_Wr_En = 1'b0;
        I_Rd_En = 1'b0;
        Sync_Clr = 1'b1;
        tick;
        Sync_Clr = 1'b0;
    endtask

    task automatic test_reset;
        Sys_Rst = 1'b1;
        tick;
        tick;
        Sys_Rst = 1'b0;
        n_chk++;
        if (O_Data_Num !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", O_Data_Num); end
        n_chk++;
        if (st !== 7'b0101000) begin n_fail++; $display("FAIL reset_status got %b want 0101000", st); end
        n_chk++;
        if (O_Rd_Data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", O_Rd_Data); end
    endtask

    task automatic test_fill_drain;
        logic [6:0] exp_st;
        for (int k = 1; k <= 5; k++) begin
            I_Wr_En = 1'b1;
            I_Wr_Data = 8'(k * 'h11);
            tick;
            exp_st = {k == 5, 1'b0, k >= 3, k <= 2, 3'b000};
            n_chk++;
            if (O_Data_Num !== 4'(k)) begin n_fail++; $display("FAIL fill_count[%0d] got %0d want %0d", k, O_Data_Num, k); end
            n_chk++;
            if (st !== exp_st) begin n_fail++; $display("FAIL fill_status[%0d] got %b want %b", k, st, exp_st); end
            n_chk++;
            if (O_Rd_Data !== 8'h11) begin n_fail++; $display("FAIL fill_head[%0d] got %h want 11", k, O_Rd_Data); end
        end
        I_Wr_En = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            n_chk++;
            if (O_Rd_Data !== 8'(k * 'h11)) begin n_fail++; $display("FAIL drain_data[%0d] got %h want %h", k, O_Rd_Data, 8'(k * 'h11)); end
            I_Rd_En = 1'b1;
            tick;
            n_chk++;
            if (O_Data_Num !== 4'(5 - k)) begin n_fail++; $display("FAIL drain_count[%0d] got %0d want %0d", k, O_Data_Num, 5 - k); end
        end
        I_Rd_En = 1'b0;
        n_chk++;
        if (st !== 7'b0101000) begin n_fail++; $display("FAIL drain_status got %b want 0101000", st); end
    endtask

    task automatic test_fwft_latency;
        flush;
        I_Wr_En = 1'b1;
        I_Wr_Data = 8'hA5;
        tick;
        I_Wr_En = 1'b0;
        n_chk++;
        if (O_Rd_Empty !== 1'b0 || O_Rd_Data !== 8'hA5) begin n_fail++; $display("FAIL fwft_first got empty=%b data=%h want empty=0 data=a5", O_Rd_Empty, O_Rd_Data); end
        I_Rd_En = 1'b1;
        tick;
        I_Rd_En = 1'b0;
        n_chk++;
        if (O_Rd_Empty !== 1'b1 || O_Almost_Empty !== 1'b1 || O_Data_Num !== 4'd0) begin n_fail++; $display("FAIL fwft_pop got empty=%b aempty=%b count=%0d want 1 1 0", O_Rd_Empty, O_Almost_Empty, O_Data_Num); end
    endtask

    task automatic test_full_both;
        flush;
        for (int k = 1; k <= 5; k++) begin
            I_Wr_En = 1'b1;
            I_Wr_Data = 8'(k);
            tick;
        end
        n_chk++;
        if (O_Wr_Full !== 1'b1) begin n_fail++; $display("FAIL full_flag got %b want 1", O_Wr_Full); end
        I_Wr_Data = 8'h99;
        I_Rd_En = 1'b1;
        tick;
        I_Wr_En = 1'b0;
        I_Rd_En = 1'b0;
        n_chk++;
        if (O_Data_Num !== 4'd4) begin n_fail++; $display("FAIL full_both_count got %0d want 4", O_Data_Num); end
        n_chk++;
        if (st !== 7'b0010110) begin n_fail++; $display("FAIL full_both_status got %b want 0010110", st); end
        n_chk++;
        if (O_Rd_Data !== 8'h02) begin n_fail++; $display("FAIL full_both_head got %h want 02", O_Rd_Data); end
        tick;
        n_chk++;
        if (O_Fifo_Err !== 1'b0 || O_Ovf_Sticky !== 1'b1) begin n_fail++; $display("FAIL ovf_hold got err=%b ovf=%b want 0 1", O_Fifo_Err, O_Ovf_Sticky); end
        flush;
        n_chk++;
        if (st !== 7'b0101000 || O_Data_Num !== 4'd0) begin n_fail++; $display("FAIL ovf_clear got %b/%0d want 0101000/0", st, O_Data_Num); end
    endtask

    task automatic test_empty_both;
        flush;
        I_Wr_En = 1'b1;
        I_Rd_En = 1'b1;
        I_Wr_Data = 8'h3C;
        tick;
        I_Wr_En = 1'b0;
        I_Rd_En = 1'b0;
        n_chk++;
        if (st !== 7'b0001101 || O_Data_Num !== 4'd1) begin n_fail++; $display("FAIL empty_both_status got %b/%0d want 0001101/1", st, O_Data_Num); end
        n_chk++;
        if (O_Rd_Data !== 8'h3C) begin n_fail++; $display("FAIL empty_both_data got %h want 3c", O_Rd_Data); end
        tick;
        n_chk++;
        if (st !== 7'b0001001) begin n_fail++; $display("FAIL err_pulse got %b want 0001001", st); end
        I_Rd_En = 1'b1;
        tick;
        tick;
        I_Rd_En = 1'b0;
        n_chk++;
        if (st !== 7'b0101101 || O_Data_Num !== 4'd0) begin n_fail++; $display("FAIL udf_read got %b/%0d want 0101101/0", st, O_Data_Num); end
        flush;
        n_chk++;
        if (st !== 7'b0101000) begin n_fail++; $display("FAIL udf_clear got %b want 0101000", st); end
    endtask

    task automatic test_count1_rw;
        flush;
        I_Wr_En = 1'b1;
        I_Wr_Data = 8'h10;
        tick;
        I_Rd_En = 1'b1;
        I_Wr_Data = 8'h20;
        tick;
        I_Wr_En = 1'b0;
        I_Rd_En = 1'b0;
        n_chk++;
        if (O_Rd_Data !== 8'h20) begin n_fail++; $display("FAIL count1_data got %h want 20", O_Rd_Data); end
        n_chk++;
        if (st !== 7'b0001000 || O_Data_Num !== 4'd1) begin n_fail++; $display("FAIL count1_status got %b/%0d want 0001000/1", st, O_Data_Num); end
    endtask

    task automatic test_random;
        logic [DW-1:0] q[$];
        logic [DW-1:0] d;
        bit w, r, wa, ra;
        flush;
        for (int i = 0; i < 1000; i++) begin
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            I_Wr_En = w;
            I_Rd_En = r;
            I_Wr_Data = d;
            wa = w && (q.size() < DD);
            ra = r && (q.size() > 0);
            tick;
            if (ra) void'(q.pop_front());
            if (wa) q.push_back(d);
            n_chk++;
            if (O_Data_Num !== 4'(q.size())) begin n_fail++; $display("FAIL rnd_count[%0d] got %0d want %0d", i, O_Data_Num, q.size()); end
            n_chk++;
            if (O_Rd_Empty !== (q.size() == 0)) begin n_fail++; $display("FAIL rnd_empty[%0d] got %b want %b", i, O_Rd_Empty, q.size() == 0); end
            if (q.size() > 0) begin
                n_chk++;
                if (O_Rd_Data !== q[0]) begin n_fail++; $display("FAIL rnd_data[%0d] got %h want %h", i, O_Rd_Data, q[0]); end
            end
        end
        I_Wr_En = 1'b0;
        I_Rd_En = 1'b0;
    endtask

    task automatic test_async_reset;
        flush;
        for (int k = 0; k < 3; k++) begin
            I_Wr_En = 1'b1;
            I_Wr_Data = 8'(8'h61 + k);
            tick;
        end
        n_chk++;
        if (O_Data_Num !== 4'd3) begin n_fail++; $display("FAIL arst_pre_count got %0d want 3", O_Data_Num); end
        I_Wr_Data = 8'hEE;
        #2 Sys_Rst = 1'b1;
        #1;
        n_chk++;
        if (O_Data_Num !== 4'd0 || st !== 7'b0101000 || O_Rd_Data !== 8'h00) begin n_fail++; $display("FAIL arst_mid got %0d/%b/%h want 0/0101000/00", O_Data_Num, st, O_Rd_Data); end
        I_Wr_En = 1'b0;
        Sys_Rst = 1'b0;
        tick;
        I_Wr_En = 1'b1;
        I_Wr_Data = 8'h7E;
        tick;
        I_Wr_En = 1'b0;
        n_chk++;
        if (O_Rd_Data !== 8'h7E || O_Data_Num !== 4'd1) begin n_fail++; $display("FAIL arst_after got %h/%0d want 7e/1", O_Rd_Data, O_Data_Num); end
    endtask

    initial begin
        test_reset;
        test_fill_drain;
        test_fwft_latency;
        test_full_both;
        test_empty_both;
        test_count1_rw;
        test_random;
        test_async_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
